// File: rtl/cpu_defs.sv
// cpu_defs: shared types for the SRAM-like memory arbiter.
package cpu_defs;
    localparam int MEMARB_AW = 32;
    localparam int MEMARB_DW = 32;
    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} memarb_state_e;
    typedef enum logic {OWN_I, OWN_D} memarb_owner_e;
    typedef struct packed {
        logic                 req;
        logic                 wr;
        logic [1:0]           size;
        logic [MEMARB_AW-1:0] addr;
        logic [MEMARB_DW-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/memarb_pick.sv
// memarb_pick: combinational fetch/data priority picker.
// MEMARB_RR_EN selects alternating priority on contention; default is data-first.
module memarb_pick
    import cpu_defs::*;
(
    input  logic          i_req,
    input  logic          d_req,
    input  memarb_owner_e last_owner,
    output memarb_owner_e grant
);
`ifdef MEMARB_RR_EN
    always_comb begin
        grant = (i_req && d_req) ? ((last_owner == OWN_I) ? OWN_D : OWN_I) :
                d_req ? OWN_D : OWN_I;
    end
`else
    logic unused_last;
    assign unused_last = last_owner;
    always_comb begin
        grant = d_req ? OWN_D : OWN_I;
    end
`endif
endmodule

// File: rtl/sram_mem_arbiter.sv
// sram_mem_arbiter: shares one SRAM-like slave port between fetch and data masters.
// MEMARB_RR_EN turns on alternating priority when both masters contend.
module sram_mem_arbiter
    import cpu_defs::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok,
    input  logic [DW-1:0] s_rdata,
    output logic          i_busy,
    output logic          d_busy
);
    memarb_state_e state;
    memarb_owner_e owner, grant, sel, last_owner;
    sram_req_t     cur;
    logic          req_on;

    memarb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .grant      (grant)
    );

`ifndef MEMARB_RR_EN
    assign last_owner = OWN_I;
`endif

    // In IDLE the picker drives the slave directly for zero-latency requests.
    always_comb begin
        sel    = (state == IDLE) ? grant : owner;
        req_on = !rst && ((state == IDLE)   ? (i_req | d_req) :
                          (state == I_ADDR) ? i_req :
                          (state == D_ADDR) ? d_req : 1'b0);
        cur = '0;
        if (req_on && sel == OWN_D)
            cur = '{req: 1'b1, wr: d_wr, size: d_size,
                    addr: MEMARB_AW'(d_addr), wdata: MEMARB_DW'(d_wdata)};
        else if (req_on)
            cur = '{req: 1'b1, wr: 1'b0, size: 2'd2,
                    addr: MEMARB_AW'(i_addr), wdata: '0};
    end

    assign s_req     = cur.req;
    assign s_wr      = cur.wr;
    assign s_size    = cur.size;
    assign s_addr    = AW'(cur.addr);
    assign s_wdata   = DW'(cur.wdata);
    assign i_addr_ok = cur.req && s_addr_ok && sel == OWN_I;
    assign d_addr_ok = cur.req && s_addr_ok && sel == OWN_D;
    assign i_data_ok = state == I_DATA && s_data_ok;
    assign d_data_ok = state == D_DATA && s_data_ok;
    assign i_busy    = state == I_ADDR || state == I_DATA;
    assign d_busy    = state == D_ADDR || state == D_DATA;
    assign i_rdata   = rst ? '0 : s_rdata;
    assign d_rdata   = rst ? '0 : s_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_I;
`ifdef MEMARB_RR_EN
            last_owner <= OWN_I;
`endif
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    owner <= grant;
                    state <= s_addr_ok ? ((grant == OWN_D) ? D_DATA : I_DATA)
                                       : ((grant == OWN_D) ? D_ADDR : I_ADDR);
                end
                I_ADDR: if (i_req && s_addr_ok) state <= I_DATA;
                D_ADDR: if (d_req && s_addr_ok) state <= D_DATA;
                I_DATA: if (s_data_ok) begin
                    state <= IDLE;
`ifdef MEMARB_RR_EN
                    last_owner <= OWN_I;
`endif
                end
                D_DATA: if (s_data_ok) begin
                    state <= IDLE;
`ifdef MEMARB_RR_EN
                    last_owner <= OWN_D;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mem_arbiter.sv
// tb_sram_mem_arbiter: directed checks of the fetch/data memory arbiter.
module tb_sram_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        i_req = 0, d_req = 0, d_wr = 0, s_addr_ok = 0, s_data_ok = 0;
    logic [1:0]  d_size = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, s_rdata = 0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, s_req, s_wr, i_busy, d_busy;
    logic [1:0]  s_size;
    logic [31:0] i_rdata, d_rdata, s_addr, s_wdata;
    int vectors = 0, miscompares = 0;

    sram_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .i_busy(i_busy), .d_busy(d_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_d;
        #1;
        chk("rst_s_req", {31'b0, s_req}, 0);
        chk("rst_okays", {28'b0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        chk("rst_busy", {30'b0, i_busy, d_busy}, 0);
        chk("rst_s_addr", s_addr, 0);
        // fetch with same-cycle address accept
        @(negedge clk); rst = 0; i_req = 1; i_addr = 32'hBFC00000; s_addr_ok = 1; #1;
        chk("t1_s_addr", s_addr, 32'hBFC00000);
        chk("t1_s_wr_size", {29'b0, s_wr, s_size}, 32'h2);
        chk("t1_i_addr_ok", {31'b0, i_addr_ok}, 1);
        chk("t1_d_addr_ok", {31'b0, d_addr_ok}, 0);
        @(negedge clk); i_req = 0; s_addr_ok = 0; #1;
        chk("t1_c1_busy", {30'b0, i_busy, d_busy}, 32'h2);
        chk("t1_c1_s_req", {31'b0, s_req}, 0);
        chk("t1_c1_i_data_ok", {31'b0, i_data_ok}, 0);
        @(negedge clk); s_data_ok = 1; s_rdata = 32'h3C1D8000; #1;
        chk("t1_i_data_ok", {31'b0, i_data_ok}, 1);
        chk("t1_i_rdata", i_rdata, 32'h3C1D8000);
        chk("t1_d_data_ok", {31'b0, d_data_ok}, 0);
        @(negedge clk); s_data_ok = 0; #1;
        chk("t1_idle_busy", {30'b0, i_busy, d_busy}, 0);
        // contention: data write wins
        i_req = 1; d_req = 1; d_wr = 1; d_size = 2; d_addr = 32'h80001000; d_wdata = 32'hDEADBEEF; s_addr_ok = 1; #1;
        chk("t2_s_wr", {31'b0, s_wr}, 1);
        chk("t2_s_addr", s_addr, 32'h80001000);
        chk("t2_s_wdata", s_wdata, 32'hDEADBEEF);
        chk("t2_okays", {30'b0, i_addr_ok, d_addr_ok}, 32'h1);
        @(negedge clk); d_req = 0; #1;
        chk("t2_dd_s_req", {31'b0, s_req}, 0);
        chk("t2_dd_i_addr_ok", {31'b0, i_addr_ok}, 0);
        chk("t2_dd_busy", {30'b0, i_busy, d_busy}, 32'h1);
        @(negedge clk); s_data_ok = 1; #1;
        chk("t2_d_data_ok", {31'b0, d_data_ok}, 1);
        chk("t2_dd_i_addr_ok2", {31'b0, i_addr_ok}, 0);
        @(negedge clk); s_data_ok = 0; #1;
        chk("t2_i_addr_ok", {31'b0, i_addr_ok}, 1);
        chk("t2_i_s_addr", s_addr, 32'hBFC00000);
        @(negedge clk); i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h11112222; #1;
        chk("t2_i_data_ok", {31'b0, i_data_ok}, 1);
        @(negedge clk); s_data_ok = 0;
        // slave stalls address phase; data master must wait
        i_req = 1; i_addr = 32'hBFC00010; #1;
        chk("t3_c0_i_addr_ok", {31'b0, i_addr_ok}, 0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); d_req = 1; d_wr = 0; d_addr = 32'h80002000; #1;
            chk("t3_s_addr", s_addr, 32'hBFC00010);
            chk("t3_d_addr_ok", {31'b0, d_addr_ok}, 0);
            chk("t3_busy", {30'b0, i_busy, d_busy}, 32'h2);
        end
        @(negedge clk); s_addr_ok = 1; #1;
        chk("t3_okays", {30'b0, i_addr_ok, d_addr_ok}, 32'h2);
        @(negedge clk); i_req = 0; s_addr_ok = 0; s_data_ok = 1; #1;
        chk("t3_i_data_ok", {31'b0, i_data_ok}, 1);
        @(negedge clk); d_req = 0; #1;
        // stray data_ok while idle
        chk("t4_stray_data_ok", {30'b0, i_data_ok, d_data_ok}, 0);
        chk("t4_stray_s_req", {31'b0, s_req}, 0);
        @(negedge clk); s_data_ok = 0; #1;
        chk("t4_idle_busy", {30'b0, i_busy, d_busy}, 0);
        // async reset during data phase
        d_req = 1; d_addr = 32'h80003000; s_addr_ok = 1; #1;
        chk("t5_d_addr_ok", {31'b0, d_addr_ok}, 1);
        @(negedge clk); d_req = 0; s_addr_ok = 0; #1;
        chk("t5_d_busy", {30'b0, i_busy, d_busy}, 32'h1);
        rst = 1; #1;
        chk("t5_rst_busy", {30'b0, i_busy, d_busy}, 0);
        chk("t5_rst_s_req", {31'b0, s_req}, 0);
        @(negedge clk); rst = 0; s_data_ok = 1; #1;
        chk("t5_late_data_ok", {30'b0, i_data_ok, d_data_ok}, 0);
        @(negedge clk); s_data_ok = 0; i_req = 1; i_addr = 32'hBFC00020; s_addr_ok = 1; #1;
        chk("t5_i_addr_ok", {31'b0, i_addr_ok}, 1);
        chk("t5_s_addr", s_addr, 32'hBFC00020);
        @(negedge clk); i_req = 0; s_addr_ok = 0; s_data_ok = 1; #1;
        chk("t5_i_data_ok", {31'b0, i_data_ok}, 1);
        @(negedge clk); s_data_ok = 0;
        // continuous contention
        i_req = 1; d_req = 1; s_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            chk("t6_grant", {30'b0, i_addr_ok, d_addr_ok}, exp_d ? 32'h1 : 32'h2);
            @(negedge clk); s_data_ok = 1; #1;
            chk("t6_data_ok", {30'b0, i_data_ok, d_data_ok}, exp_d ? 32'h1 : 32'h2);
            @(negedge clk); s_data_ok = 0;
        end
        i_req = 0; d_req = 0; s_addr_ok = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
